// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one cipher round per clock with an on-the-fly key schedule.
// A block takes Nr+1 cycles from accepted start to the done pulse; start is also accepted in the done cycle.
module aes_encrypt_iter #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [0:127]     plaintext,
    input  logic [32*Nk-1:0] key,
    output logic             busy,
    output logic             done,
    output logic [0:127]     ciphertext
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned RND_W = 4;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(Nr);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t             fsm_q;
    logic [RND_W-1:0] round_q;
    logic [BLK_W-1:0] state_q;
    logic [BLK_W-1:0] rk_q;
    logic [BLK_W-1:0] rk_next;
    logic [BLK_W-1:0] shifted;
    logic [BLK_W-1:0] round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
        return r;
    endfunction

    // Bytes are column-major: byte 4*c+row sits at the MSB end for c=0, row=0.
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [BLK_W-1:0] key_expand(input logic [BLK_W-1:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w3 = rk[31:0];
        t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rc, 24'h0};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Round datapath; the final round skips MixColumns.
    always_comb begin
        rk_next   = key_expand(rk_q, rcon(round_q));
        shifted   = shift_rows(sub_bytes(state_q));
        round_out = ((round_q == LAST_RND) ? shifted : mix_columns(shifted)) ^ rk_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ciphertext <= '0;
            round_q    <= '0;
            state_q    <= '0;
            rk_q       <= '0;
        end else begin
            done <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q <= plaintext ^ BLK_W'(key);
                        rk_q    <= BLK_W'(key);
                        round_q <= RND_W'(1);
                        busy    <= 1'b1;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= round_out;
                    rk_q    <= rk_next;
                    if (round_q == LAST_RND) begin
                        ciphertext <= round_out;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        fsm_q      <= IDLE;
                    end else begin
                        round_q <= round_q + RND_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
